fetch_sequencer: RTL and testbench

Sequences instruction fetch around the program counter: generates fetch addresses, issues requests to local-store instruction memory, and buffers returned instruction pairs for decode. It arbitrates PC redirects from the branch unit and the flush/exception path, and discards in-flight fetches made stale by a redirect. It sits between the PC register, instruction memory and the decode/issue stage.

---
 rtl/fetch_sequencer_pkg.sv | 17 +
 rtl/fetch_buf_fifo.sv | 77 +++++++
 rtl/fetch_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: PC geometry, branch-unit id and FSM encodings.
package fetch_sequencer_pkg;

  localparam int unsigned PC_W = 10;
  localparam int unsigned INC  = 2;

  localparam logic [2:0] BRANCH_UNIT_ID = 3'd7;

  localparam logic [0:0] ST_HALT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Redirect targets must land on a pair boundary.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~(PC_W'(INC - 1));
  endfunction

endpackage

// File: rtl/fetch_buf_fifo.sv
// Synchronous FIFO of {pc, data} with synchronous clear and occupancy count.
// With HAS_DATA=0 only the pc field is stored (used as the outstanding-request tag queue).
module fetch_buf_fifo #(
  parameter int unsigned  DEPTH    = 2,
  parameter int unsigned  PC_BITS  = 10,
  parameter int unsigned  DATA_W   = 64,
  parameter bit           HAS_DATA = 1'b1,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_push,
  input  logic [PC_BITS-1:0] i_push_pc,
  input  logic [DATA_W-1:0]  i_push_data,
  input  logic               i_pop,
  output logic [PC_BITS-1:0] o_pc,
  output logic [DATA_W-1:0]  o_data,
  output logic [CW-1:0]      o_count,
  output logic               o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [PC_BITS-1:0] r_pc_mem [DEPTH];
  logic               w_push;
  logic               w_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clr) r_pc_mem[r_wr_ptr] <= i_push_pc;
  end

  // Outputs read as zero when empty so the head never shows stale storage.
  assign o_pc = o_empty ? '0 : r_pc_mem[r_rd_ptr];

  if (HAS_DATA) begin : g_data
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    always_ff @(posedge clk) begin
      if (w_push && !i_clr) r_data_mem[r_wr_ptr] <= i_push_data;
    end
    assign o_data = o_empty ? '0 : r_data_mem[r_rd_ptr];
  end else begin : g_no_data
    logic w_unused_data;
    assign w_unused_data = ^i_push_data;
    assign o_data        = '0;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues credit-limited fetches, tracks in-flight PCs, buffers pairs
// for decode and discards stale responses after redirects. FETCH_SEQ_PERF_EN adds perf counters.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned INSN_W    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [PC_W-1:0]   i_start_pc,
  input  logic              i_stop,
  input  logic              i_br_valid,
  input  logic [PC_W-1:0]   i_br_target,
  input  logic              i_flush_valid,
  input  logic [PC_W-1:0]   i_flush_target,
  output logic              o_imem_req_valid,
  input  logic              i_imem_req_ready,
  output logic [PC_W-1:0]   o_imem_addr,
  input  logic              i_imem_rsp_valid,
  input  logic [INSN_W-1:0] i_imem_rsp_data,
  output logic              o_dec_valid,
  input  logic              i_dec_ready,
  output logic [PC_W-1:0]   o_dec_pc,
  output logic [INSN_W-1:0] o_dec_insn,
  output logic [PC_W-1:0]   o_fetch_pc,
  output logic              o_busy
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [15:0]       o_perf_redirects,
  output logic [15:0]       o_perf_discards,
  output logic [15:0]       o_perf_stall_cycles
`endif
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [0:0]      r_state;
  logic [PC_W-1:0] r_fetch_pc;
  logic [CW-1:0]   r_discard;

  logic            w_run;
  logic            w_redirect;
  logic            w_redirect_run;
  logic [PC_W-1:0] w_target;
  logic [CW-1:0]   w_outstanding;
  logic [CW-1:0]   w_occ;
  logic            w_credit;
  logic            w_req_fire;
  logic            w_discard_now;
  logic            w_rsp_keep;
  logic            w_buf_empty;
  logic [PC_W-1:0] w_tag_pc;
  logic            w_unused_tag_empty;
  logic            w_unused_tag_data;
  logic [CW-1:0]   w_discard_d;
  logic [PC_W-1:0] w_fetch_pc_d;
  logic [0:0]      w_state_d;

  assign w_run          = (r_state == ST_RUN);
  assign w_redirect     = i_br_valid || i_flush_valid;
  assign w_redirect_run = w_redirect && w_run;
  assign w_target       = align_pc(i_flush_valid ? i_flush_target : i_br_target);

  // Outstanding plus buffered never exceeds BUF_DEPTH, so every response has a slot.
  assign w_credit         = ({1'b0, w_outstanding} + {1'b0, w_occ}) < SW'(BUF_DEPTH);
  assign o_imem_req_valid = w_run && !w_redirect && w_credit;
  assign o_imem_addr      = r_fetch_pc;
  assign w_req_fire       = o_imem_req_valid && i_imem_req_ready;

  assign w_discard_now = (r_discard != '0);
  assign w_rsp_keep    = i_imem_rsp_valid && !w_discard_now && !w_redirect_run;

  fetch_buf_fifo #(
    .DEPTH    (BUF_DEPTH),
    .PC_BITS  (PC_W),
    .DATA_W   (1),
    .HAS_DATA (1'b0)
  ) u_tag_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (1'b0),
    .i_push      (w_req_fire),
    .i_push_pc   (r_fetch_pc),
    .i_push_data (1'b0),
    .i_pop       (i_imem_rsp_valid),
    .o_pc        (w_tag_pc),
    .o_data      (w_unused_tag_data),
    .o_count     (w_outstanding),
    .o_empty     (w_unused_tag_empty)
  );

  fetch_buf_fifo #(
    .DEPTH    (BUF_DEPTH),
    .PC_BITS  (PC_W),
    .DATA_W   (INSN_W),
    .HAS_DATA (1'b1)
  ) u_fetch_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_redirect_run),
    .i_push      (w_rsp_keep),
    .i_push_pc   (w_tag_pc),
    .i_push_data (i_imem_rsp_data),
    .i_pop       (i_dec_ready),
    .o_pc        (o_dec_pc),
    .o_data      (o_dec_insn),
    .o_count     (w_occ),
    .o_empty     (w_buf_empty)
  );

  assign o_dec_valid = !w_buf_empty;
  assign o_fetch_pc  = r_fetch_pc;
  assign o_busy      = w_run || (w_outstanding != '0) || w_discard_now;

  always_comb begin
    w_discard_d = r_discard;
    if (w_redirect_run) begin
      // A response landing in the redirect cycle is itself dropped.
      w_discard_d = i_imem_rsp_valid ? (w_outstanding - CW'(1)) : w_outstanding;
    end else if (i_imem_rsp_valid && w_discard_now) begin
      w_discard_d = r_discard - CW'(1);
    end
  end

  always_comb begin
    w_fetch_pc_d = r_fetch_pc;
    if (w_redirect)            w_fetch_pc_d = w_target;
    else if (!w_run && i_start) w_fetch_pc_d = i_start_pc;
    else if (w_req_fire)       w_fetch_pc_d = r_fetch_pc + PC_W'(INC);
  end

  always_comb begin
    w_state_d = r_state;
    if (i_stop)       w_state_d = ST_HALT;
    else if (i_start) w_state_d = ST_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_HALT;
      r_fetch_pc <= '0;
      r_discard  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_fetch_pc <= w_fetch_pc_d;
      r_discard  <= w_discard_d;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] r_perf_redirects;
  logic [15:0] r_perf_discards;
  logic [15:0] r_perf_stall;
  logic        w_rsp_drop;
  logic        w_stall;

  assign w_rsp_drop = i_imem_rsp_valid && (w_discard_now || w_redirect_run);
  assign w_stall    = w_run && !w_redirect && !w_credit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_redirects <= '0;
      r_perf_discards  <= '0;
      r_perf_stall     <= '0;
    end else begin
      if (w_redirect && (r_perf_redirects != 16'hFFFF)) r_perf_redirects <= r_perf_redirects + 16'd1;
      if (w_rsp_drop && (r_perf_discards != 16'hFFFF))  r_perf_discards  <= r_perf_discards + 16'd1;
      if (w_stall && (r_perf_stall != 16'hFFFF))        r_perf_stall     <= r_perf_stall + 16'd1;
    end
  end

  assign o_perf_redirects    = r_perf_redirects;
  assign o_perf_discards     = r_perf_discards;
  assign o_perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed tables and sequences plus randomized traffic
// against a queue-based model of fetched, in-flight and buffered instruction pairs.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_start = 1'b0;
  logic [9:0]  i_start_pc = '0;
  logic        i_stop = 1'b0;
  logic        i_br_valid = 1'b0;
  logic [9:0]  i_br_target = '0;
  logic        i_flush_valid = 1'b0;
  logic [9:0]  i_flush_target = '0;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready = 1'b0;
  logic [9:0]  o_imem_addr;
  logic        i_imem_rsp_valid = 1'b0;
  logic [63:0] i_imem_rsp_data = '0;
  logic        o_dec_valid;
  logic        i_dec_ready = 1'b0;
  logic [9:0]  o_dec_pc;
  logic [63:0] o_dec_insn;
  logic [9:0]  o_fetch_pc;
  logic        o_busy;
`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] o_perf_redirects, o_perf_discards, o_perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_start          (i_start),
    .i_start_pc       (i_start_pc),
    .i_stop           (i_stop),
    .i_br_valid       (i_br_valid),
    .i_br_target      (i_br_target),
    .i_flush_valid    (i_flush_valid),
    .i_flush_target   (i_flush_target),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_addr      (o_imem_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .o_dec_valid      (o_dec_valid),
    .i_dec_ready      (i_dec_ready),
    .o_dec_pc         (o_dec_pc),
    .o_dec_insn       (o_dec_insn),
    .o_fetch_pc       (o_fetch_pc),
    .o_busy           (o_busy)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .o_perf_redirects    (o_perf_redirects),
    .o_perf_discards     (o_perf_discards),
    .o_perf_stall_cycles (o_perf_stall_cycles)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mem_word(input int a);
    return {32'(a) * 32'h0001_0003, 32'hCAFE_0000 | 32'(a)};
  endfunction

  // Model: pairs in flight (stale once a running redirect overtakes them) and pairs buffered.
  typedef struct { int pc; bit stale; } infl_t;
  typedef struct { int addr; int due; } mreq_t;
  bit    m_run;
  int    m_fpc;
  infl_t m_infl[$];
  int    m_buf[$];
  mreq_t mq[$];
  int    last_due;
  int    lat_min = 1, lat_max = 1, rdy_pct = 100;
  int    issued[$];
  int    delivered[$];

  task automatic model_reset();
    m_run = 1'b0; m_fpc = 0; last_due = 0;
    m_infl.delete(); m_buf.delete(); mq.delete();
  endtask

  // Entered and left at a falling edge; caller drives control inputs beforehand.
  task automatic cycle();
    mreq_t r;
    infl_t f;
    bit    redirect, exp_req;
    int    tgt, due;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      r = mq.pop_front();
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = mem_word(r.addr);
    end
    i_imem_req_ready = ($urandom_range(99) < rdy_pct);
    #1;
    redirect = i_br_valid || i_flush_valid;
    tgt      = (i_flush_valid ? int'(i_flush_target) : int'(i_br_target)) & ~1;
    exp_req  = m_run && !redirect && ((m_infl.size() + m_buf.size()) < 2);
    check("req_valid", o_imem_req_valid, exp_req);
    check("imem_addr", o_imem_addr, m_fpc);
    check("fetch_pc", o_fetch_pc, m_fpc);
    check("dec_valid", o_dec_valid, m_buf.size() > 0);
    check("dec_pc", o_dec_pc, (m_buf.size() > 0) ? m_buf[0] : 0);
    check("dec_insn", o_dec_insn, (m_buf.size() > 0) ? mem_word(m_buf[0]) : 64'd0);
    check("busy", o_busy, m_run || (m_infl.size() > 0));
    if (o_imem_req_valid && i_imem_req_ready) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{int'(o_imem_addr), due});
    end
    if (m_buf.size() > 0 && i_dec_ready) delivered.push_back(m_buf.pop_front());
    if (i_imem_rsp_valid && m_infl.size() > 0) begin
      f = m_infl.pop_front();
      if (!f.stale && !(redirect && m_run)) m_buf.push_back(f.pc);
    end
    if (exp_req && i_imem_req_ready) begin
      issued.push_back(m_fpc);
      m_infl.push_back('{m_fpc, 1'b0});
    end
    if (redirect && m_run) begin
      m_buf.delete();
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
    end
    if (redirect)                         m_fpc = tgt;
    else if (!m_run && i_start)           m_fpc = int'(i_start_pc);
    else if (exp_req && i_imem_req_ready) m_fpc = (m_fpc + 2) % 1024;
    if (i_stop)       m_run = 1'b0;
    else if (i_start) m_run = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic halt_and_drain();
    i_dec_ready = 1'b1;
    i_stop = 1'b1;
    cycle();
    i_stop = 1'b0;
    issued.delete();
    for (int i = 0; i < 40 && (o_busy || o_dec_valid); i++) cycle();
    check("drain_busy", o_busy, 1'b0);
    check("drain_dec_valid", o_dec_valid, 1'b0);
    check("no_req_after_stop", issued.size(), 0);
  endtask

  task automatic check_q(input string name, input int q[$], input int idx, input int exp);
    if (q.size() > idx) check(name, q[idx], exp);
    else check({name, "_missing"}, q.size(), idx + 1);
  endtask

  typedef struct {
    logic       br;
    logic [9:0] bt;
    logic       fl;
    logic [9:0] ft;
    logic [9:0] exp_pc;
  } redir_vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    redir_vec_t rv [6];
    rv[0] = '{1'b1, 10'h100, 1'b1, 10'h200, 10'h200};
    rv[1] = '{1'b1, 10'h101, 1'b0, 10'h000, 10'h100};
    rv[2] = '{1'b0, 10'h000, 1'b1, 10'h3FF, 10'h3FE};
    rv[3] = '{1'b1, 10'h055, 1'b0, 10'h000, 10'h054};
    rv[4] = '{1'b1, 10'h123, 1'b1, 10'h0AB, 10'h0AA};
    rv[5] = '{1'b0, 10'h000, 1'b1, 10'h000, 10'h000};

    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_req_valid", o_imem_req_valid, 1'b0);
    check("rst_imem_addr", o_imem_addr, 10'h0);
    check("rst_dec_valid", o_dec_valid, 1'b0);
    check("rst_dec_pc", o_dec_pc, 10'h0);
    check("rst_dec_insn", o_dec_insn, 64'h0);
    check("rst_fetch_pc", o_fetch_pc, 10'h0);
    check("rst_busy", o_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    i_dec_ready = 1'b1;
    repeat (2) cycle();

    // Redirects while halted only move fetch_pc.
    for (int i = 0; i < 6; i++) begin
      i_br_valid = rv[i].br; i_br_target = rv[i].bt;
      i_flush_valid = rv[i].fl; i_flush_target = rv[i].ft;
      cycle();
      i_br_valid = 1'b0; i_flush_valid = 1'b0;
      check($sformatf("redir_vec%0d", i), o_fetch_pc, rv[i].exp_pc);
    end

    // Start at 0x010 with decode stalled: two credits, then resume at 0x014.
    lat_min = 1; lat_max = 1;
    i_dec_ready = 1'b0;
    issued.delete(); delivered.delete();
    i_start = 1'b1; i_start_pc = 10'h010;
    cycle();
    i_start = 1'b0;
    repeat (10) cycle();
    check("stall_issued", issued.size(), 2);
    check("stall_req_low", o_imem_req_valid, 1'b0);
    i_dec_ready = 1'b1;
    repeat (8) cycle();
    check_q("issue0", issued, 0, 'h010);
    check_q("issue1", issued, 1, 'h012);
    check_q("issue2", issued, 2, 'h014);
    check_q("deliv0", delivered, 0, 'h010);
    check_q("deliv1", delivered, 1, 'h012);
    check_q("deliv2", delivered, 2, 'h014);

    halt_and_drain();

    // Branch with two requests in flight: both stale responses dropped.
    lat_min = 4; lat_max = 4;
    i_start = 1'b1; i_start_pc = 10'h040;
    cycle();
    i_start = 1'b0;
    issued.delete();
    for (int i = 0; i < 10 && issued.size() < 2; i++) cycle();
    i_br_valid = 1'b1; i_br_target = 10'h100;
    issued.delete(); delivered.delete();
    cycle();
    i_br_valid = 1'b0;
    repeat (12) cycle();
    check_q("br_issue0", issued, 0, 'h100);
    check_q("br_deliv0", delivered, 0, 'h100);

    halt_and_drain();

    // Address wrap at the top of the PC space.
    lat_min = 1; lat_max = 1;
    issued.delete(); delivered.delete();
    i_start = 1'b1; i_start_pc = 10'h3FE;
    cycle();
    i_start = 1'b0;
    repeat (6) cycle();
    check_q("wrap_issue0", issued, 0, 'h3FE);
    check_q("wrap_issue1", issued, 1, 'h000);
    check_q("wrap_deliv1", delivered, 1, 'h000);

    // Asynchronous reset mid-fetch with two outstanding.
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 12 && m_infl.size() < 2; i++) cycle();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req_valid", o_imem_req_valid, 1'b0);
    check("mid_rst_imem_addr", o_imem_addr, 10'h0);
    check("mid_rst_dec_valid", o_dec_valid, 1'b0);
    check("mid_rst_dec_pc", o_dec_pc, 10'h0);
    check("mid_rst_dec_insn", o_dec_insn, 64'h0);
    check("mid_rst_fetch_pc", o_fetch_pc, 10'h0);
    check("mid_rst_busy", o_busy, 1'b0);
    model_reset();
    i_imem_rsp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();

    // Randomized traffic.
    lat_min = 1; lat_max = 3; rdy_pct = 70;
    for (int n = 0; n < 3000; n++) begin
      i_start        = ($urandom_range(9) == 0);
      i_start_pc     = 10'($urandom);
      i_stop         = ($urandom_range(39) == 0);
      i_br_valid     = ($urandom_range(19) == 0);
      i_br_target    = 10'($urandom);
      i_flush_valid  = ($urandom_range(29) == 0);
      i_flush_target = 10'($urandom);
      i_dec_ready    = ($urandom_range(99) < 70);
      cycle();
    end
    i_start = 1'b0; i_br_valid = 1'b0; i_flush_valid = 1'b0;
    rdy_pct = 100;
    halt_and_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
